// File: rtl/ifu_pkg.sv
// Shared IFU types and constants used by the instruction-fetch miss path.
package ifu_pkg;

  localparam int TAG_WIDTH  = 8;
  localparam int LINE_WIDTH = 64;

  localparam int MISS_TIMEOUT_CYCLES = 16;
  localparam int MISS_MAX_RETRIES    = 2;
  localparam int MISS_CNT_WIDTH      = 16;

  typedef enum logic [1:0] {
    MISS_IDLE = 2'd0,
    MISS_REQ  = 2'd1,
    MISS_WAIT = 2'd2,
    MISS_RSP  = 2'd3
  } ifu_miss_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [MISS_CNT_WIDTH-1:0] sat_inc(input logic [MISS_CNT_WIDTH-1:0] value);
    return (value == '1) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/ifu_miss_timer.sv
// Loadable up-counter with clear, enable and a terminal-count flag.
module ifu_miss_timer #(
  parameter int WIDTH    = 4,
  parameter int TERMINAL = 15
) (
  input  logic             Clock,
  input  logic             Rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             terminal
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge Clock) begin
    if (Rst)          count_reg <= '0;
    else if (clear)   count_reg <= '0;
    else if (load)    count_reg <= load_value;
    else if (enable)  count_reg <= count_reg + 1'b1;
  end

  assign terminal = (count_reg == WIDTH'(TERMINAL));

endmodule

// File: rtl/ifu_miss_ctrl.sv
// Instruction-cache miss controller: one outstanding line fetch, tag-filtered
// responses, timeout with bounded retry, flush abort and a saturating miss count.
module ifu_miss_ctrl #(
  parameter int TAG_WIDTH      = ifu_pkg::TAG_WIDTH,
  parameter int LINE_WIDTH     = ifu_pkg::LINE_WIDTH,
  parameter int TIMEOUT_CYCLES = ifu_pkg::MISS_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES    = ifu_pkg::MISS_MAX_RETRIES
) (
  input  logic                  Clock,
  input  logic                  Rst,
  input  logic [TAG_WIDTH-1:0]  cache_reqTagIn,
  input  logic                  cache_reqTagValidIn,
  output logic [TAG_WIDTH-1:0]  cache_rspTagOut,
  output logic [LINE_WIDTH-1:0] cache_rspInsLineOut,
  output logic                  cache_rspInsLineValidOut,
  output logic [TAG_WIDTH-1:0]  mem_reqTagOut,
  output logic                  mem_reqValidOut,
  input  logic                  mem_reqReadyIn,
  input  logic [TAG_WIDTH-1:0]  mem_rspTagIn,
  input  logic [LINE_WIDTH-1:0] mem_rspInsLineIn,
  input  logic                  mem_rspValidIn,
  input  logic                  flushIn,
  output logic                  errorOut,
  output logic                  busyOut,
  output logic [15:0]           missCountOut,
  output logic [1:0]            stateOut
);
  import ifu_pkg::*;

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
  localparam int RETRY_W = (MAX_RETRIES == 0) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

  ifu_miss_state_t state_reg, state_next;
  logic [TAG_WIDTH-1:0]      pend_tag_reg, pend_tag_next;
  logic [TAG_WIDTH-1:0]      rsp_tag_reg, rsp_tag_next;
  logic [LINE_WIDTH-1:0]     rsp_line_reg, rsp_line_next;
  logic [RETRY_W-1:0]        retry_reg, retry_next;
  logic [MISS_CNT_WIDTH-1:0] miss_cnt_reg, miss_cnt_next;
  logic                      error_reg, error_next;

  logic timer_clear;
  logic timer_terminal;
  logic rsp_match;

  assign rsp_match = mem_rspValidIn && (mem_rspTagIn == pend_tag_reg);

  ifu_miss_timer #(
    .WIDTH    (TIMER_W),
    .TERMINAL (TIMEOUT_CYCLES - 1)
  ) u_timer (
    .Clock      (Clock),
    .Rst        (Rst),
    .clear      (timer_clear),
    .load       (1'b0),
    .load_value ('0),
    .enable     (state_reg == MISS_WAIT),
    .terminal   (timer_terminal)
  );

  always_ff @(posedge Clock) begin
    if (Rst) begin
      state_reg    <= MISS_IDLE;
      pend_tag_reg <= '0;
      rsp_tag_reg  <= '0;
      rsp_line_reg <= '0;
      retry_reg    <= '0;
      miss_cnt_reg <= '0;
      error_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pend_tag_reg <= pend_tag_next;
      rsp_tag_reg  <= rsp_tag_next;
      rsp_line_reg <= rsp_line_next;
      retry_reg    <= retry_next;
      miss_cnt_reg <= miss_cnt_next;
      error_reg    <= error_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pend_tag_next = pend_tag_reg;
    rsp_tag_next  = rsp_tag_reg;
    rsp_line_next = rsp_line_reg;
    retry_next    = retry_reg;
    miss_cnt_next = miss_cnt_reg;
    error_next    = 1'b0;
    timer_clear   = 1'b0;

    // Flush overrides everything in flight; the miss statistic is left intact.
    if (flushIn) begin
      state_next  = MISS_IDLE;
      retry_next  = '0;
      timer_clear = 1'b1;
    end else begin
      unique case (state_reg)
        MISS_IDLE: begin
          if (cache_reqTagValidIn) begin
            pend_tag_next = cache_reqTagIn;
            retry_next    = '0;
            miss_cnt_next = sat_inc(miss_cnt_reg);
            state_next    = MISS_REQ;
          end
        end
        MISS_REQ: begin
          if (mem_reqReadyIn) begin
            timer_clear = 1'b1;
            state_next  = MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          // A match in the terminal cycle still wins over the timeout.
          if (rsp_match) begin
            rsp_tag_next  = mem_rspTagIn;
            rsp_line_next = mem_rspInsLineIn;
            state_next    = MISS_RSP;
          end else if (timer_terminal) begin
            if (retry_reg < RETRY_LIMIT) begin
              retry_next = retry_reg + 1'b1;
              state_next = MISS_REQ;
            end else begin
              error_next = 1'b1;
              state_next = MISS_IDLE;
            end
          end
        end
        MISS_RSP: state_next = MISS_IDLE;
        default:  state_next = MISS_IDLE;
      endcase
    end
  end

  assign cache_rspTagOut          = rsp_tag_reg;
  assign cache_rspInsLineOut      = rsp_line_reg;
  assign cache_rspInsLineValidOut = (state_reg == MISS_RSP);
  assign mem_reqTagOut            = pend_tag_reg;
  assign mem_reqValidOut          = (state_reg == MISS_REQ);
  assign errorOut                 = error_reg;
  assign busyOut                  = (state_reg != MISS_IDLE);
  assign missCountOut             = miss_cnt_reg;
  assign stateOut                 = state_reg;

endmodule

// File: tb/tb_ifu_miss_ctrl.sv
// Directed plus randomized bench for ifu_miss_ctrl against a cycle-level
// behavioural model of the miss protocol.
module tb_ifu_miss_ctrl;
  import ifu_pkg::*;

  localparam int TO = 4;
  localparam int MR = 1;
  localparam int TW = TAG_WIDTH;
  localparam int LW = LINE_WIDTH;

  logic          Clock = 1'b0;
  logic          Rst = 1'b1;
  logic [TW-1:0] cache_reqTagIn = '0;
  logic          cache_reqTagValidIn = 1'b0;
  logic [TW-1:0] cache_rspTagOut;
  logic [LW-1:0] cache_rspInsLineOut;
  logic          cache_rspInsLineValidOut;
  logic [TW-1:0] mem_reqTagOut;
  logic          mem_reqValidOut;
  logic          mem_reqReadyIn = 1'b0;
  logic [TW-1:0] mem_rspTagIn = '0;
  logic [LW-1:0] mem_rspInsLineIn = '0;
  logic          mem_rspValidIn = 1'b0;
  logic          flushIn = 1'b0;
  logic          errorOut;
  logic          busyOut;
  logic [15:0]   missCountOut;
  logic [1:0]    stateOut;

  always #5 Clock = ~Clock;

  ifu_miss_ctrl #(
    .TIMEOUT_CYCLES (TO),
    .MAX_RETRIES    (MR)
  ) dut (
    .Clock                    (Clock),
    .Rst                      (Rst),
    .cache_reqTagIn           (cache_reqTagIn),
    .cache_reqTagValidIn      (cache_reqTagValidIn),
    .cache_rspTagOut          (cache_rspTagOut),
    .cache_rspInsLineOut      (cache_rspInsLineOut),
    .cache_rspInsLineValidOut (cache_rspInsLineValidOut),
    .mem_reqTagOut            (mem_reqTagOut),
    .mem_reqValidOut          (mem_reqValidOut),
    .mem_reqReadyIn           (mem_reqReadyIn),
    .mem_rspTagIn             (mem_rspTagIn),
    .mem_rspInsLineIn         (mem_rspInsLineIn),
    .mem_rspValidIn           (mem_rspValidIn),
    .flushIn                  (flushIn),
    .errorOut                 (errorOut),
    .busyOut                  (busyOut),
    .missCountOut             (missCountOut),
    .stateOut                 (stateOut)
  );

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;

  // Reference model: phase numbers follow the documented debug encoding.
  int            m_phase;
  logic [TW-1:0] m_tag, m_rtag;
  logic [LW-1:0] m_rline;
  int            m_age, m_tries, m_cnt;
  bit            m_err;

  // Scoreboard of observed transactions.
  int            sb_req = 0, sb_ins = 0, sb_err = 0;
  int            acc_cycle = 0, err_cycle = 0;
  logic [TW-1:0] last_ins_tag = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("state", 64'(stateOut), 64'(m_phase));
    chk("busy", 64'(busyOut), 64'(m_phase != 0));
    chk("mem_valid", 64'(mem_reqValidOut), 64'(m_phase == 1));
    chk("mem_tag", 64'(mem_reqTagOut), 64'(m_tag));
    chk("ins_valid", 64'(cache_rspInsLineValidOut), 64'(m_phase == 3));
    chk("ins_tag", 64'(cache_rspTagOut), 64'(m_rtag));
    chk("ins_line", 64'(cache_rspInsLineOut), 64'(m_rline));
    chk("error", 64'(errorOut), 64'(m_err));
    chk("miss_cnt", 64'(missCountOut), 64'(m_cnt));
    if (mem_reqValidOut === 1'b1 && mem_reqReadyIn) begin
      sb_req++;
      acc_cycle = cyc;
      $display("cycle %0d: mem request accepted tag=%0h", cyc, mem_reqTagOut);
    end
    if (cache_rspInsLineValidOut === 1'b1) begin
      sb_ins++;
      last_ins_tag = cache_rspTagOut;
      $display("cycle %0d: insert tag=%0h line=%0h", cyc, cache_rspTagOut, cache_rspInsLineOut);
    end
    if (errorOut === 1'b1) begin
      sb_err++;
      err_cycle = cyc;
      $display("cycle %0d: retries exhausted", cyc);
    end
  endtask

  task automatic model_step();
    if (Rst) begin
      m_phase = 0; m_tag = '0; m_rtag = '0; m_rline = '0;
      m_age = 0; m_tries = 0; m_cnt = 0; m_err = 0;
      return;
    end
    m_err = 0;
    if (flushIn) begin
      m_phase = 0; m_age = 0; m_tries = 0;
    end else begin
      case (m_phase)
        0: if (cache_reqTagValidIn) begin
             m_tag = cache_reqTagIn; m_tries = 0;
             if (m_cnt < 65535) m_cnt++;
             m_phase = 1;
           end
        1: if (mem_reqReadyIn) begin m_age = 0; m_phase = 2; end
        2: begin
             m_age++;
             if (mem_rspValidIn && mem_rspTagIn == m_tag) begin
               m_rtag = mem_rspTagIn; m_rline = mem_rspInsLineIn; m_phase = 3;
             end else if (m_age == TO) begin
               if (m_tries < MR) begin m_tries++; m_phase = 1; end
               else begin m_err = 1; m_phase = 0; end
             end
           end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic tick();
    check_all();
    model_step();
    @(posedge Clock);
    @(negedge Clock);
    cyc++;
  endtask

  int req0, ins0, err0;

  task automatic snap();
    req0 = sb_req; ins0 = sb_ins; err0 = sb_err;
  endtask

  initial begin
    // Reset
    model_step();
    @(posedge Clock);
    @(negedge Clock);
    tick();
    Rst = 1'b0;
    tick();

    // Basic fetch
    snap();
    cache_reqTagValidIn = 1'b1; cache_reqTagIn = 8'h12; mem_reqReadyIn = 1'b1;
    tick();
    cache_reqTagValidIn = 1'b0;
    tick();
    tick();
    mem_rspValidIn = 1'b1; mem_rspTagIn = 8'h12; mem_rspInsLineIn = {8{8'hA5}};
    tick();
    mem_rspValidIn = 1'b0;
    tick();
    tick();
    chk("basic_req", 64'(sb_req - req0), 64'd1);
    chk("basic_ins", 64'(sb_ins - ins0), 64'd1);
    chk("basic_tag", 64'(last_ins_tag), 64'h12);
    chk("basic_cnt", 64'(missCountOut), 64'd1);

    // Backpressure then stale filter
    snap();
    cache_reqTagValidIn = 1'b1; cache_reqTagIn = 8'h12; mem_reqReadyIn = 1'b0;
    tick();
    cache_reqTagValidIn = 1'b0;
    repeat (5) tick();
    mem_reqReadyIn = 1'b1;
    tick();
    mem_reqReadyIn = 1'b0;
    mem_rspValidIn = 1'b1; mem_rspTagIn = 8'h34; mem_rspInsLineIn = 64'h3434_0000_3434_0000;
    tick();
    mem_rspTagIn = 8'h12; mem_rspInsLineIn = 64'h0123_4567_89AB_CDEF;
    tick();
    mem_rspValidIn = 1'b0;
    tick();
    tick();
    chk("bp_req", 64'(sb_req - req0), 64'd1);
    chk("stale_ins", 64'(sb_ins - ins0), 64'd1);
    chk("stale_tag", 64'(last_ins_tag), 64'h12);
    chk("bp_err", 64'(sb_err - err0), 64'd0);

    // Timeout with one retry, then error
    snap();
    cache_reqTagValidIn = 1'b1; cache_reqTagIn = 8'h56; mem_reqReadyIn = 1'b1;
    tick();
    cache_reqTagValidIn = 1'b0;
    tick();
    repeat (TO) tick();
    tick();
    repeat (TO) tick();
    tick();
    tick();
    chk("to_req", 64'(sb_req - req0), 64'd2);
    chk("to_err", 64'(sb_err - err0), 64'd1);
    chk("to_err_delay", 64'(err_cycle - acc_cycle), 64'(TO + 1));
    chk("to_ins", 64'(sb_ins - ins0), 64'd0);

    // Matching response in the timeout cycle wins
    snap();
    cache_reqTagValidIn = 1'b1; cache_reqTagIn = 8'h21;
    tick();
    cache_reqTagValidIn = 1'b0;
    tick();
    repeat (TO - 1) tick();
    mem_rspValidIn = 1'b1; mem_rspTagIn = 8'h21; mem_rspInsLineIn = 64'hDEAD_BEEF_2121_2121;
    tick();
    mem_rspValidIn = 1'b0;
    tick();
    tick();
    chk("edge_req", 64'(sb_req - req0), 64'd1);
    chk("edge_ins", 64'(sb_ins - ins0), 64'd1);
    chk("edge_err", 64'(sb_err - err0), 64'd0);

    // Flush in WAIT, late matching response ignored
    snap();
    cache_reqTagValidIn = 1'b1; cache_reqTagIn = 8'h77;
    tick();
    cache_reqTagValidIn = 1'b0;
    tick();
    tick();
    flushIn = 1'b1;
    tick();
    flushIn = 1'b0;
    mem_rspValidIn = 1'b1; mem_rspTagIn = 8'h77; mem_rspInsLineIn = 64'h7777;
    tick();
    mem_rspValidIn = 1'b0;
    repeat (2) tick();
    chk("flush_ins", 64'(sb_ins - ins0), 64'd0);
    chk("flush_err", 64'(sb_err - err0), 64'd0);
    chk("flush_state", 64'(stateOut), 64'd0);

    // Flush during RSP still delivers the pulse
    snap();
    cache_reqTagValidIn = 1'b1; cache_reqTagIn = 8'h42;
    tick();
    cache_reqTagValidIn = 1'b0;
    tick();
    mem_rspValidIn = 1'b1; mem_rspTagIn = 8'h42; mem_rspInsLineIn = 64'h4242_4242;
    tick();
    mem_rspValidIn = 1'b0; flushIn = 1'b1;
    tick();
    flushIn = 1'b0;
    tick();
    chk("flush_rsp_ins", 64'(sb_ins - ins0), 64'd1);

    // Reset while a request is pending
    cache_reqTagValidIn = 1'b1; cache_reqTagIn = 8'h99; mem_reqReadyIn = 1'b0;
    tick();
    cache_reqTagValidIn = 1'b0;
    tick();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    chk("rst_valid", 64'(mem_reqValidOut), 64'd0);
    chk("rst_cnt", 64'(missCountOut), 64'd0);
    tick();

    // Counter saturation via backdoor preload
    force dut.miss_cnt_reg = 16'hFFFE;
    #1;
    release dut.miss_cnt_reg;
    m_cnt = 16'hFFFE;
    repeat (2) begin
      cache_reqTagValidIn = 1'b1; cache_reqTagIn = 8'h10;
      tick();
      cache_reqTagValidIn = 1'b0; flushIn = 1'b1;
      tick();
      flushIn = 1'b0;
    end
    tick();
    chk("sat_cnt", 64'(missCountOut), 64'hFFFF);

    // Randomized traffic
    repeat (600) begin
      Rst = ($urandom_range(99) == 0);
      flushIn = ($urandom_range(29) == 0);
      cache_reqTagValidIn = ($urandom_range(9) < 7);
      cache_reqTagIn = ($urandom_range(1) == 1) ? 8'h12 : TW'($urandom);
      mem_reqReadyIn = $urandom_range(1) == 1;
      mem_rspValidIn = ($urandom_range(9) < 4);
      mem_rspTagIn = ($urandom_range(1) == 1) ? m_tag : TW'($urandom);
      mem_rspInsLineIn = {$urandom, $urandom};
      tick();
    end
    Rst = 1'b0; flushIn = 1'b0; cache_reqTagValidIn = 1'b0; mem_rspValidIn = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
